// File: rtl/instruction_fetch_if.sv
// Fetch-unit bus bundle: ROM read port, redirect input and the
// valid/ready instruction stream toward decode.
interface instruction_fetch_if;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  // fetch unit side
  modport master (
    output rom_addr,
    input  rom_data,
    input  redirect_valid,
    input  redirect_pc,
    output inst_valid,
    input  inst_ready,
    output inst_data,
    output inst_pc
  );

  // ROM / decode / branch-unit side
  modport slave (
    input  rom_addr,
    output rom_data,
    output redirect_valid,
    output redirect_pc,
    input  inst_valid,
    output inst_ready,
    input  inst_data,
    input  inst_pc
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch: sequential PC generator reading a combinational ROM,
// feeding a 2-entry {pc, word} skid FIFO toward decode. A redirect flushes
// the FIFO and restarts fetch at the (word aligned) target on the next edge.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  instruction_fetch_if.master bus
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  // fetch PC is kept as a word address; the byte offset is always zero
  localparam logic [29:0] RESET_WA = RESET_PC[31:2];

  logic [29:0]      fetch_wa_q;
  entry_t [1:0]     fifo_q;
  logic [1:0]       count_q;

  logic             pop;
  logic             push;
  logic [1:0]       wr_idx;
  entry_t           tail_in;
  logic [29:0]      redirect_wa;
  logic [1:0]       unused_redirect_lsb;

  assign redirect_wa         = bus.redirect_pc[31:2];
  assign unused_redirect_lsb = bus.redirect_pc[1:0];

  assign bus.rom_addr   = {fetch_wa_q, 2'b00};
  assign bus.inst_valid = (count_q != 2'd0);
  assign bus.inst_pc    = fifo_q[0].pc;
  assign bus.inst_data  = fifo_q[0].word;

  // a pop in a redirect cycle still retires the head; only the push is blocked
  assign pop  = bus.inst_valid & bus.inst_ready;
  assign push = ~bus.redirect_valid & ((count_q != 2'd2) | pop);

  // tail slot after the head (if any) has shifted out
  assign wr_idx  = count_q - {1'b0, pop};
  assign tail_in = '{pc: bus.rom_addr, word: bus.rom_data};

  // fetch PC: reset > redirect > sequential advance (wraps mod 2^32)
  always_ff @(posedge clk) begin
    if (!rst_n)
      fetch_wa_q <= RESET_WA;
    else if (bus.redirect_valid)
      fetch_wa_q <= redirect_wa;
    else if (push)
      fetch_wa_q <= fetch_wa_q + 30'd1;
  end

  // occupancy: flushed by reset or redirect, otherwise +push -pop
  always_ff @(posedge clk) begin
    if (!rst_n || bus.redirect_valid)
      count_q <= 2'd0;
    else begin
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO payload: shift head out on pop, then write the new word at the tail
  always_ff @(posedge clk) begin
    if (rst_n && !bus.redirect_valid) begin
      if (pop)
        fifo_q[0] <= fifo_q[1];
      if (push)
        fifo_q[wr_idx[0]] <= tail_in;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus a random phase,
// checked by a scoreboard fed from a stream-level reference model.
module tb_instruction_fetch;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instruction_fetch_if ifc ();
  instruction_fetch_if ifw ();

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a >> 2) + 32'd100;
  endfunction

  assign ifc.rom_data = rom_word(ifc.rom_addr);
  assign ifw.rom_data = rom_word(ifw.rom_addr);
  assign ifw.inst_ready = 1'b1;
  assign ifw.redirect_valid = 1'b0;
  assign ifw.redirect_pc = 32'h0;

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));
  instruction_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (.clk(clk), .rst_n(rst_n), .bus(ifw));

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  // The accepted stream is the sequential PC run from the last restart
  // point; the model tracks the head PC and how many words are buffered.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] head_pc, gen_pc;
  int          m_count;
  bit          started = 0;
  bit          hold_v = 0;
  logic [31:0] hold_pc, hold_data;

  function automatic void restart(input logic [31:0] t);
    m_count = 0;
    head_pc = t;
    gen_pc  = t;
    exp_q.delete();
  endfunction

  always @(negedge clk) begin
    exp_t e;
    bit   pop_m;
    if (started) begin
      chk("inst_valid", {31'b0, ifc.inst_valid}, {31'b0, (m_count != 0)});
      chk("rom_addr", ifc.rom_addr, head_pc + 32'(m_count * 4));
      if (hold_v) begin
        chk("stall_pc", ifc.inst_pc, hold_pc);
        chk("stall_data", ifc.inst_data, hold_data);
      end
      if (rst_n && m_count != 0 && ifc.inst_ready) begin
        e = exp_q.pop_front();
        chk("pop_pc", ifc.inst_pc, e.pc);
        chk("pop_data", ifc.inst_data, e.data);
      end
    end
    hold_v = 0;
    // advance model across the coming edge
    if (!rst_n) begin
      restart(32'h0000_0000);
      started = 1;
    end else if (started) begin
      if (ifc.redirect_valid)
        restart({ifc.redirect_pc[31:2], 2'b00});
      else begin
        pop_m = (m_count != 0) && ifc.inst_ready;
        if (pop_m) head_pc = head_pc + 32'd4;
        m_count = m_count - int'(pop_m) + 1;
        if (m_count > 2) m_count = 2;
        if (!pop_m && ifc.inst_valid) begin
          hold_v    = 1;
          hold_pc   = ifc.inst_pc;
          hold_data = ifc.inst_data;
        end
      end
    end
    if (started)
      while (exp_q.size() < 4) begin
        exp_q.push_back('{pc: gen_pc, data: rom_word(gen_pc)});
        gen_pc = gen_pc + 32'd4;
      end
  end

  // ---------------- wrap-around instance ----------------
  initial begin
    logic [31:0] wexp [3];
    wexp[0] = 32'hFFFF_FFF8;
    wexp[1] = 32'hFFFF_FFFC;
    wexp[2] = 32'h0000_0000;
    @(posedge rst_n);
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("wrap_valid", {31'b0, ifw.inst_valid}, 32'd1);
      chk("wrap_pc", ifw.inst_pc, wexp[k]);
      chk("wrap_data", ifw.inst_data, rom_word(wexp[k]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bit found;
    ifc.inst_ready = 1'b1;
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc = 32'h0;
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(8);

    // backpressure from the first valid
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    ifc.inst_ready = 1'b0;
    step(6);
    chk("bp_rom_addr", ifc.rom_addr, 32'h8);
    chk("bp_inst_pc", ifc.inst_pc, 32'h0);
    ifc.inst_ready = 1'b1;
    step(6);

    // redirect while head pc 12 is popped
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (ifc.inst_valid && ifc.inst_pc == 32'd12) found = 1;
      else step(1);
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL redir_wait: head pc 12 never seen within 20 cycles");
    end
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc = 32'h34;
    step(1);
    ifc.redirect_valid = 1'b0;
    chk("redir_flush_valid", {31'b0, ifc.inst_valid}, 32'd0);
    step(1);
    chk("redir_target_pc", ifc.inst_pc, 32'h34);
    step(4);

    // misaligned redirect
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc = 32'h37;
    step(1);
    ifc.redirect_valid = 1'b0;
    chk("mis_rom_addr", ifc.rom_addr, 32'h34);
    step(1);
    chk("mis_inst_pc", ifc.inst_pc, 32'h34);
    step(3);

    // wrap through redirect
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc = 32'hFFFF_FFF8;
    step(1);
    ifc.redirect_valid = 1'b0;
    step(5);

    // mid-stream reset with a full FIFO
    ifc.inst_ready = 1'b0;
    step(3);
    rst_n = 1'b0;
    step(1);
    chk("mid_valid", {31'b0, ifc.inst_valid}, 32'd0);
    rst_n = 1'b1;
    ifc.inst_ready = 1'b1;
    step(1);
    chk("mid_first_pc", ifc.inst_pc, 32'h0);
    step(3);

    // random traffic
    repeat (600) begin
      ifc.inst_ready = ($urandom_range(0, 3) != 0);
      ifc.redirect_valid = ($urandom_range(0, 11) == 0);
      ifc.redirect_pc = $urandom;
      rst_n = ($urandom_range(0, 99) != 0);
      step(1);
    end
    rst_n = 1'b1;
    ifc.redirect_valid = 1'b0;
    ifc.inst_ready = 1'b1;
    step(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, which is the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port rom_addr, output, 32 bits: byte address to the program ROM; bits [1:0] always 0.
REQ-005 SHALL have port rom_data, input, 32 bits: ROM word at rom_addr, combinational, valid in the same cycle.
REQ-006 SHALL have port redirect_valid, input, 1 bit: branch/jump taken; restart fetch at redirect_pc.
REQ-007 SHALL have port redirect_pc, input, 32 bits: redirect target; bits [1:0] ignored and treated as 0.
REQ-008 SHALL have port inst_valid, output, 1 bit: inst_data/inst_pc hold a valid fetched instruction.
REQ-009 SHALL have port inst_ready, input, 1 bit: decode accepts the head instruction this cycle.
REQ-010 SHALL have port inst_data, output, 32 bits: head instruction word.
REQ-011 SHALL have port inst_pc, output, 32 bits: byte address of the head instruction.

Function
REQ-012 SHALL hold fetch_pc (32 bits) and a 2-entry FIFO of {pc, word} pairs with count 0..2.
REQ-013 SHALL drive rom_addr = {fetch_pc[31:2], 2'b00} combinationally in every cycle.
REQ-014 SHALL define pop = inst_valid & inst_ready, and a handshake completes only when both are 1 on the same edge.
REQ-015 SHALL define push = !redirect_valid & (count < 2 | pop); on push, write {fetch_pc, rom_data} at the tail and set fetch_pc <= fetch_pc + 4.
REQ-016 SHALL perform the fetch_pc increment modulo 2^32, so 32'hFFFF_FFFC is followed by 32'h0000_0000.
REQ-017 SHALL allow push and pop on the same edge, leaving count unchanged and preserving order.
REQ-018 SHALL drive inst_valid = (count != 0), with inst_data and inst_pc taken from the head entry.
REQ-019 SHALL hold inst_valid, inst_data and inst_pc stable while inst_valid = 1 and inst_ready = 0.
REQ-020 SHALL, on redirect_valid = 1, set count to 0 (flushing all entries), set fetch_pc to {redirect_pc[31:2], 2'b00}, and perform no push.
REQ-021 SHALL treat a pop in the redirect cycle as a completed handshake for the current head; that instruction is not repeated.
REQ-022 SHALL give redirect priority over push; pop acceptance in that cycle is unaffected.
REQ-023 SHALL have a redirect latency of 1 edge: redirect sampled at edge N, target word pushed at edge N+1, target visible on inst_* after N+1 when inst_ready is held 1.
REQ-024 SHALL deliver one instruction per cycle in steady state while inst_ready = 1 and no redirect occurs.
REQ-025 SHALL, when count = 2 and inst_ready = 0, hold fetch_pc and perform no push.
REQ-026 SHALL present inst_data/inst_pc values of don't-care while inst_valid = 0, and the bench shall not check them.

Reset
REQ-027 SHALL, while rst_n = 0 at a rising edge, set fetch_pc <= RESET_PC & ~3 and count <= 0.
REQ-028 SHALL, during reset, drive inst_valid = 0 and rom_addr = RESET_PC & ~3.
REQ-029 SHALL give reset priority over redirect, push and pop.
REQ-030 SHALL make reset asserted mid-stream discard all buffered entries, with no handshake completing at that edge.
REQ-031 SHALL, after rst_n rises, push the first word (pc = RESET_PC) on the first edge; inst_valid = 1 after that edge.

Verification
REQ-032 SHALL cover streaming: ROM[i] = i+100, RESET_PC = 0, inst_ready = 1 -> pcs 0,4,8,12 with data 100,101,102,103 on consecutive cycles, no gaps.
REQ-033 SHALL cover backpressure: inst_ready = 0 for 5 cycles after the first valid -> count saturates at 2, rom_addr stuck at 8, inst_pc = 0 stable; on release, 0,4,8 delivered in order with none lost or duplicated.
REQ-034 SHALL cover redirect: redirect_valid = 1 with redirect_pc = 32'h34 while head pc = 12 is popped -> next valid inst_pc = 32'h34 one edge later, then 32'h38, with no pc 16 or 20 delivered.
REQ-035 SHALL cover a misaligned redirect: redirect_pc = 32'h37 -> rom_addr = 32'h34, inst_pc = 32'h34.
REQ-036 SHALL cover wrap-around: RESET_PC = 32'hFFFF_FFF8 -> inst_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-037 SHALL cover mid-stream reset: rst_n = 0 for 1 cycle with count = 2 -> inst_valid = 0 after that edge, then pc = RESET_PC delivered first.
